// File: rtl/data_mem_arbiter_pkg.sv
// Shared widths, port identifiers and the read-return tag format for the
// DataMemory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of both requester ports and the DataMemory port. The slave modport is
// the arbiter's view; the master modport is the requesters-plus-RAM view.
interface data_mem_arbiter_if;
  import dmem_arb_pkg::*;

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_ena;
  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [DATA_W-1:0] mem_dina;
  logic [DATA_W-1:0] mem_douta;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_ena, mem_wea, mem_addra, mem_dina,
    input  mem_douta
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_ena, mem_wea, mem_addra, mem_dina,
    output mem_douta
  );

endinterface

// File: rtl/data_mem_arbiter_rr.sv
// Two-way round-robin grant. The priority pointer names the port that wins a
// tie and flips away from whichever port was last accepted.
module rr_arbiter_2 (
  input  logic       clka,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  typedef enum logic {PRIO_CPU = 1'b0, PRIO_LDR = 1'b1} prio_e;

  prio_e prio_q, prio_d;

  // Priority pointer register
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PRIO_CPU;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Grant selection and pointer update
  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (prio_q == PRIO_LDR) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    if (accept_i) begin
      prio_d = gnt_o[0] ? PRIO_LDR : PRIO_CPU;
    end else begin
      prio_d = prio_q;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises the CPU and loader ports onto the single DataMemory port and
// steers each read datum back to its issuer via a tagged return pipeline.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic             clka,
  input  logic             rst_n,
  data_mem_arbiter_if.slave bus
);

  logic [1:0]        req_s;
  logic [1:0]        arb_gnt_s;
  logic [1:0]        gnt_s;
  logic              accept_s;
  logic              sel_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  logic              ena_q, wea_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dina_q;

  tag_t [RD_LATENCY:0] tag_q, tag_d;
  tag_t                ret_s;
  logic                rvalid0_s, rvalid1_s;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  assign req_s = {bus.p1_req, bus.p0_req};

  rr_arbiter_2 u_arb (
    .clka     (clka),
    .rst_n    (rst_n),
    .req_i    (req_s),
    .accept_i (accept_s),
    .gnt_o    (arb_gnt_s)
  );

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign gnt_s    = arb_gnt_s & {2{rst_n}};
  assign accept_s = |gnt_s;
  assign sel_s    = gnt_s[1];

  assign sel_we_s    = sel_s ? bus.p1_we    : bus.p0_we;
  assign sel_addr_s  = sel_s ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata_s = sel_s ? bus.p1_wdata : bus.p0_wdata;

  assign bus.p0_gnt = gnt_s[0];
  assign bus.p1_gnt = gnt_s[1];

  // Issue register: address and data hold when nothing is accepted
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      ena_q  <= 1'b0;
      wea_q  <= 1'b0;
      addr_q <= '0;
      dina_q <= '0;
    end else begin
      ena_q <= accept_s;
      wea_q <= accept_s & sel_we_s;
      if (accept_s) begin
        addr_q <= sel_addr_s;
        dina_q <= sel_wdata_s;
      end
    end
  end

  assign bus.mem_ena   = ena_q;
  assign bus.mem_wea   = wea_q;
  assign bus.mem_addra = addr_q;
  assign bus.mem_dina  = dina_q;

  // Stage 0 lines up with the RAM-drive cycle; the last stage with douta.
  always_comb begin
    tag_d        = tag_q;
    tag_d[0].vld = accept_s & ~sel_we_s;
    tag_d[0].id  = sel_s;
    for (int i = 1; i <= RD_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Tag shift register
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign ret_s     = tag_q[RD_LATENCY];
  assign rvalid0_s = ret_s.vld & (ret_s.id == PORT_CPU);
  assign rvalid1_s = ret_s.vld & (ret_s.id == PORT_LDR);

  // Last delivered datum per port, shown while that port has no return
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0_s) rdata0_q <= bus.mem_douta;
      if (rvalid1_s) rdata1_q <= bus.mem_douta;
    end
  end

  assign bus.p0_rvalid = rvalid0_s;
  assign bus.p1_rvalid = rvalid1_s;
  assign bus.p0_rdata  = rvalid0_s ? bus.mem_douta : rdata0_q;
  assign bus.p1_rdata  = rvalid1_s ? bus.mem_douta : rdata1_q;

endmodule
